control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/control_fsm_pkg.sv | 93 +++++++++
 rtl/control_fsm_if.sv | 33 +++
 rtl/control_fsm_alu_decoder.sv | 31 +++
 rtl/control_fsm.sv | 133 +++++++++++++
 tb/tb_control_fsm.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM: state encodings,
// opcodes, ALU/immediate codes and the per-state control word.
package control_fsm_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

    localparam logic [F3_W-1:0] F3_ADDSUB = 3'b000;
    localparam logic [F3_W-1:0] F3_SLT    = 3'b010;
    localparam logic [F3_W-1:0] F3_OR     = 3'b110;
    localparam logic [F3_W-1:0] F3_AND    = 3'b111;

    localparam logic [SEL_W-1:0] IMM_I = 2'b00;
    localparam logic [SEL_W-1:0] IMM_S = 2'b01;
    localparam logic [SEL_W-1:0] IMM_B = 2'b10;
    localparam logic [SEL_W-1:0] IMM_J = 2'b11;

    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
    localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    // Moore control word produced by each state
    typedef struct packed {
        logic             pc_update;
        logic             branch;
        logic             adr_src;
        logic             mem_write;
        logic             ir_write;
        logic             reg_write;
        logic [SEL_W-1:0] result_src;
        logic [SEL_W-1:0] alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        alu_op_t          alu_op;
    } ctrl_t;

    // Immediate format depends only on the opcode, not on the state
    function automatic logic [SEL_W-1:0] imm_src_for(input logic [OP_W-1:0] op);
        logic [SEL_W-1:0] imm;
        case (op)
            OP_LW, OP_I: imm = IMM_I;
            OP_SW:       imm = IMM_S;
            OP_BEQ:      imm = IMM_B;
            OP_JAL:      imm = IMM_J;
            default:     imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction fields in, datapath control strobes/selects out.
interface control_fsm_if;
    import control_fsm_pkg::*;

    logic [OP_W-1:0]    op;
    logic [F3_W-1:0]    funct3;
    logic               funct7b5;
    logic               Zero;

    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegWrite;
    logic [SEL_W-1:0]   ResultSrc;
    logic [SEL_W-1:0]   ALUSrcA;
    logic [SEL_W-1:0]   ALUSrcB;
    logic [ALUC_W-1:0]  ALUControl;
    logic [SEL_W-1:0]   ImmSrc;
    logic [STATE_W-1:0] state;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, state
    );
endinterface

// File: rtl/control_fsm_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus instruction fields to ALUControl.
module alu_decoder
    import control_fsm_pkg::*;
(
    input  alu_op_t           i_alu_op,
    input  logic [F3_W-1:0]   i_funct3,
    input  logic              i_op5,
    input  logic              i_funct7b5,
    output logic [ALUC_W-1:0] o_alu_control_c
);

    always_comb begin
        o_alu_control_c = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control_c = ALU_ADD;
            ALUOP_SUB: o_alu_control_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // only R-type (op[5]=1) distinguishes sub; addi ignores bit 30
                    F3_ADDSUB: o_alu_control_c = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:    o_alu_control_c = ALU_SLT;
                    F3_OR:     o_alu_control_c = ALU_OR;
                    F3_AND:    o_alu_control_c = ALU_AND;
                    default:   o_alu_control_c = ALU_ADD;
                endcase
            end
            default: o_alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode,
// memory, execute and writeback steps, plus ALU and immediate decode.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    control_fsm_if.slave  bus
);

    state_t            r_state;
    state_t            w_next_state;
    ctrl_t             w_ctrl;
    logic [ALUC_W-1:0] w_alu_control;

    // State register; reset returns to FETCH without waiting for a clock
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Moore control word
    always_comb begin
        w_next_state = S_FETCH;
        w_ctrl       = '0;
        case (r_state)
            S_FETCH: begin
                w_next_state      = S_DECODE;
                w_ctrl.ir_write   = 1'b1;
                w_ctrl.pc_update  = 1'b1;
                w_ctrl.alu_src_a  = SRCA_PC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.alu_op     = ALUOP_ADD;
                w_ctrl.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:         w_next_state = S_EXECUTER;
                    OP_I:         w_next_state = S_EXECUTEI;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_JAL:       w_next_state = S_JAL;
                    default:      w_next_state = S_FETCH;
                endcase
                // branch target is precomputed here from OldPC + imm
                w_ctrl.alu_src_a = SRCA_OLDPC;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                w_next_state     = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                w_next_state      = S_MEMWB;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                w_next_state      = S_FETCH;
                w_ctrl.result_src = RES_DATA;
                w_ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_next_state      = S_FETCH;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.adr_src    = 1'b1;
                w_ctrl.mem_write  = 1'b1;
            end
            S_EXECUTER: begin
                w_next_state     = S_ALUWB;
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_RS2;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                w_next_state     = S_ALUWB;
                w_ctrl.alu_src_a = SRCA_RS1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_next_state      = S_FETCH;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
            end
            S_BEQ: begin
                w_next_state      = S_FETCH;
                w_ctrl.alu_src_a  = SRCA_RS1;
                w_ctrl.alu_src_b  = SRCB_RS2;
                w_ctrl.alu_op     = ALUOP_SUB;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                w_next_state      = S_ALUWB;
                w_ctrl.alu_src_a  = SRCA_OLDPC;
                w_ctrl.alu_src_b  = SRCB_FOUR;
                w_ctrl.alu_op     = ALUOP_ADD;
                w_ctrl.result_src = RES_ALUOUT;
                w_ctrl.pc_update  = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op        (w_ctrl.alu_op),
        .i_funct3        (bus.funct3),
        .i_op5           (bus.op[5]),
        .i_funct7b5      (bus.funct7b5),
        .o_alu_control_c (w_alu_control)
    );

    // Write enables are gated by reset so nothing commits while it is held
    assign bus.PCWrite    = RST_N & (w_ctrl.pc_update | (w_ctrl.branch & bus.Zero));
    assign bus.IRWrite    = RST_N & w_ctrl.ir_write;
    assign bus.MemWrite   = RST_N & w_ctrl.mem_write;
    assign bus.RegWrite   = RST_N & w_ctrl.reg_write;
    assign bus.AdrSrc     = w_ctrl.adr_src;
    assign bus.ResultSrc  = w_ctrl.result_src;
    assign bus.ALUSrcA    = w_ctrl.alu_src_a;
    assign bus.ALUSrcB    = w_ctrl.alu_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = imm_src_for(bus.op);
    assign bus.state      = STATE_W'(r_state);

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: random instruction stream against a
// per-instruction reference of the state walk and per-state controls.
module tb_control_fsm;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    typedef struct packed {
        logic [3:0] state;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] aluc;
        logic [1:0] imm;
    } exp_t;

    logic clk;
    logic rst_n;
    logic mon_en;
    int   total;
    int   bad;
    exp_t sb[$];

    control_fsm_if bus ();

    control_fsm dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ALU operation an R/I instruction asks for
    function automatic logic [2:0] arith_code(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7);
        case (f3)
            3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic exp_t model_step(input int st, input logic [6:0] op,
                                        input logic [2:0] f3, input logic f7, input logic zero);
        exp_t e;
        e       = '0;
        e.state = 4'(st);
        if (op == LW || op == IT) e.imm = 2'b00;
        else if (op == SW)        e.imm = 2'b01;
        else if (op == BEQ)       e.imm = 2'b10;
        else if (op == JAL)       e.imm = 2'b11;
        case (st)
            0:  begin e.pcw = 1; e.irw = 1; e.srcb = 2; e.res = 2; end
            1:  begin e.srca = 1; e.srcb = 1; end
            2:  begin e.srca = 2; e.srcb = 1; end
            3:  e.adr = 1;
            4:  begin e.res = 1; e.regw = 1; end
            5:  begin e.adr = 1; e.memw = 1; end
            6:  begin e.srca = 2; e.aluc = arith_code(op, f3, f7); end
            7:  begin e.srca = 2; e.srcb = 1; e.aluc = arith_code(op, f3, f7); end
            8:  e.regw = 1;
            9:  begin e.srca = 2; e.aluc = 3'b001; e.pcw = zero; end
            10: begin e.srca = 1; e.srcb = 2; e.pcw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // Issue one instruction at the start of its FETCH cycle and queue its walk
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic zero, input int max_steps);
        int seq[$];
        case (op)
            LW:      seq = '{0, 1, 2, 3, 4};
            SW:      seq = '{0, 1, 2, 5};
            RT:      seq = '{0, 1, 6, 8};
            IT:      seq = '{0, 1, 7, 8};
            BEQ:     seq = '{0, 1, 9};
            JAL:     seq = '{0, 1, 10, 8};
            default: seq = '{0, 1};
        endcase
        while (seq.size() > max_steps) void'(seq.pop_back());
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = zero;
        foreach (seq[i]) sb.push_back(model_step(seq[i], op, f3, f7, zero));
        repeat (seq.size()) @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents one control word
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        if (mon_en) begin
            a = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc};
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow actual=%0h required=none", a);
            end else begin
                e = sb.pop_front();
                check($sformatf("ctrl_st%0d_op%0h", e.state, bus.op), 32'(a), 32'(e));
            end
        end
    end

    initial begin
        logic [6:0] rop;
        logic [6:0] ops [6];
        ops = '{LW, SW, RT, IT, BEQ, JAL};
        total = 0;
        bad = 0;
        mon_en = 1'b0;
        rst_n = 1'b0;
        bus.op = LW;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b0;
        bus.Zero = 1'b1;

        #3;
        check("rst_state",    32'(bus.state),      0);
        check("rst_pcwrite",  32'(bus.PCWrite),    0);
        check("rst_irwrite",  32'(bus.IRWrite),    0);
        check("rst_memwrite", 32'(bus.MemWrite),   0);
        check("rst_regwrite", 32'(bus.RegWrite),   0);
        check("rst_adrsrc",   32'(bus.AdrSrc),     0);
        check("rst_result",   32'(bus.ResultSrc),  2);
        check("rst_srcb",     32'(bus.ALUSrcB),    2);
        check("rst_aluctl",   32'(bus.ALUControl), 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_state", 32'(bus.state), 0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        issue(LW,  3'b000, 1'b0, 1'b0, 99);
        issue(SW,  3'b010, 1'b0, 1'b0, 99);
        issue(RT,  3'b000, 1'b1, 1'b0, 99);
        issue(RT,  3'b000, 1'b0, 1'b0, 99);
        issue(RT,  3'b111, 1'b0, 1'b0, 99);
        issue(IT,  3'b000, 1'b1, 1'b0, 99);
        issue(BEQ, 3'b000, 1'b0, 1'b1, 99);
        issue(BEQ, 3'b000, 1'b0, 1'b0, 99);
        issue(JAL, 3'b000, 1'b0, 1'b1, 99);
        issue(7'b0000000, 3'b000, 1'b0, 1'b1, 99);

        for (int n = 0; n < 80; n++) begin
            int k;
            k = $urandom_range(0, 7);
            if (k < 6)       rop = ops[k];
            else if (k == 6) rop = 7'b0000000;
            else             rop = 7'($urandom);
            issue(rop, 3'($urandom), 1'($urandom), 1'($urandom), 99);
        end

        // Abort a store in MEMWRITE with an asynchronous reset
        issue(SW, 3'b010, 1'b0, 1'b0, 3);
        mon_en = 1'b0;
        check("sb_drained",      32'(sb.size()),    0);
        check("abort_pre_state", 32'(bus.state),    5);
        check("abort_pre_memw",  32'(bus.MemWrite), 1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_memw",  32'(bus.MemWrite), 0);
        check("abort_state", 32'(bus.state),    0);
        check("abort_pcw",   32'(bus.PCWrite),  0);
        check("abort_irw",   32'(bus.IRWrite),  0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("release_irw", 32'(bus.IRWrite), 1);
        @(posedge clk);
        #1;
        check("release_first_edge", 32'(bus.state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
